// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time RAM loader.
// State encodings, byte width and the length decoding rule live here so the
// loader and anything that inspects it agree on them.
package loader_pkg;

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned MEM_DEPTH = 256;
   localparam int unsigned CNT_W     = 9;

   // A length byte of zero encodes a full 256-byte load.
   localparam bit LEN_ZERO_MEANS_MAX = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StBase,
      StLen,
      StData,
      StWrite,
      StCsum,
      StDone
   } state_e;

   // Turn the stream length byte into the number of payload bytes to write.
   function automatic logic [CNT_W-1:0] decode_len(input logic [BYTE_W-1:0] len_byte);
      if (LEN_ZERO_MEANS_MAX && (len_byte == '0)) begin
         return CNT_W'(MEM_DEPTH);
      end
      return {1'b0, len_byte};
   endfunction

endpackage

// File: rtl/ram_loader.sv
// Boot-time program loader in front of the 256x8 RAM.
// Consumes a valid/ready byte stream {base, length, payload...} and writes the
// payload into consecutive RAM locations, owning the RAM bus while busy.
// Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
module ram_loader
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   output logic [BYTE_W-1:0] addr,
   output logic              we,
   output logic [BYTE_W-1:0] data_out,
   output logic              data_drive,
   output logic              busy,
   output logic              done,
   output logic              err
);

`ifdef LOADER_CHECKSUM_EN
   localparam state_e StAfterLast = StCsum;
`else
   localparam state_e StAfterLast = StDone;
`endif

   state_e             state_q, state_d;
   logic [BYTE_W-1:0]  ptr_q, ptr_d;
   logic [BYTE_W-1:0]  data_q, data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               we_q, we_d;
   logic               drive_q, drive_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0]  sum_q, sum_d;
   logic               err_q, err_d;
`endif

   logic xfer;

   // A byte moves only when the registered ready is high.
   assign xfer = in_valid && ready_q;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d   = sum_q;
      err_d   = err_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StBase;
`ifdef LOADER_CHECKSUM_EN
               sum_d   = '0;
               err_d   = 1'b0;
`endif
            end
         end
         StBase: begin
            if (xfer) begin
               ptr_d   = in_data;
               state_d = StLen;
            end
         end
         StLen: begin
            if (xfer) begin
               cnt_d   = decode_len(in_data);
               // Only reachable when zero does not mean a full load.
               state_d = (decode_len(in_data) == '0) ? StAfterLast : StData;
            end
         end
         StData: begin
            if (xfer) begin
               data_d  = in_data;
`ifdef LOADER_CHECKSUM_EN
               sum_d   = BYTE_W'(sum_q + in_data);
`endif
               state_d = StWrite;
            end
         end
         StWrite: begin
            // RAM samples addr/data on the edge that closes this cycle.
            ptr_d   = BYTE_W'(ptr_q + 1'b1);
            cnt_d   = CNT_W'(cnt_q - 1'b1);
            state_d = (cnt_q == CNT_W'(1)) ? StAfterLast : StData;
         end
`ifdef LOADER_CHECKSUM_EN
         StCsum: begin
            if (xfer) begin
               if (BYTE_W'(sum_q + in_data) != '0) begin
                  err_d = 1'b1;
               end
               state_d = StDone;
            end
         end
`endif
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are flopped from the next state so they never depend on in_valid combinationally.
      we_d    = (state_d == StWrite);
      drive_d = (state_d == StWrite);
      ready_d = (state_d == StBase) || (state_d == StLen) ||
                (state_d == StData) || (state_d == StCsum);
      busy_d  = (state_d != StIdle);
      done_d  = (state_d == StDone);
   end

   // State and output registers; reset clears the bus controls immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         drive_q <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         drive_q <= drive_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
         err_q   <= err_d;
`endif
      end
   end

   assign in_ready   = ready_q;
   assign addr       = ptr_q;
   assign we         = we_q;
   assign data_out   = data_q;
   assign data_drive = drive_q;
   assign busy       = busy_q;
   assign done       = done_q;
`ifdef LOADER_CHECKSUM_EN
   assign err        = err_q;
`else
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: a RAM model, a write scoreboard and one
// task per scenario. Checksum scenarios run when LOADER_CHECKSUM_EN is defined.
module tb_ram_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic [7:0] addr;
   logic       we;
   logic [7:0] data_out;
   logic       data_drive;
   logic       busy;
   logic       done;
   logic       err;

   int checks = 0;
   int errors = 0;
   int we_cnt = 0;
   int done_cnt = 0;
   int cyc = 0;
   int done_cyc = 0;

   logic [7:0]  mem [256];
   logic [15:0] sb [$];
   logic [15:0] exp_w;

   ram_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .addr       (addr),
      .we         (we),
      .data_out   (data_out),
      .data_drive (data_drive),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // RAM model: writes land on the rising edge that closes a we cycle.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (we) mem[addr] <= data_out;
   end

   // Write monitor and scoreboard compare, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (we) begin
            we_cnt++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL write_sb: unexpected write addr=%h data=%h, required no write",
                        addr, data_out);
            end else begin
               exp_w = sb.pop_front();
               if ({addr, data_out, data_drive} !== {exp_w, 1'b1}) begin
                  errors++;
                  $display("FAIL write_sb: got addr=%h data=%h drive=%b, required addr=%h data=%h drive=1",
                           addr, data_out, data_drive, exp_w[15:8], exp_w[7:0]);
               end
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] csum_of(input logic [7:0] pl[$]);
      logic [7:0] s;
      s = 8'h00;
      foreach (pl[i]) s = s + pl[i];
      return 8'h00 - s;
   endfunction

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Present one byte from a negedge and hold it until the loader takes it.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int t;
      t = 0;
      if (gaps) begin
         while ($urandom_range(0, 2) == 0) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   // Full load transaction with scoreboard pushes, timing and end-state checks.
   task automatic load(input logic [7:0] base, input logic [7:0] len_b, input logic [7:0] pl[$],
                       input bit gaps, input int glitch_at, input logic [7:0] csum);
      int         n, rdy_cyc, d0, t, exp_off;
      logic       exp_err;
      logic [7:0] a;
      n  = pl.size();
      d0 = done_cnt;
`ifdef LOADER_CHECKSUM_EN
      exp_err = ((8'(csum_of(pl) - csum)) != 8'h00);
      exp_off = 2 + 2 * n + 1;
`else
      exp_err = 1'b0;
      exp_off = 2 + 2 * n;
`endif
      pulse_start();
      rdy_cyc = cyc;
      checks++;
      if ({busy, in_ready} !== 2'b11) begin
         errors++;
         $display("FAIL start_resp: busy=%b in_ready=%b, required 1 1", busy, in_ready);
      end
      send_byte(base, gaps);
      send_byte(len_b, gaps);
      for (int i = 0; i < n; i++) begin
         if (i == glitch_at) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         a = base + 8'(i);
         sb.push_back({a, pl[i]});
         send_byte(pl[i], gaps);
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(csum, gaps);
`else
      // Offer a trailing byte; the loader must finish without taking it.
      in_valid = 1'b1;
      in_data  = csum;
`endif
      #1;
      t = 0;
      while (done_cnt == d0 && t < 20) begin
         @(negedge clk);
         #1;
         t++;
      end
      in_valid = 1'b0;
      checks++;
      if (done_cnt == d0) begin
         errors++;
         $display("FAIL done_timeout: no done pulse, required one");
      end else if (!gaps && glitch_at < 0 && (done_cyc - rdy_cyc) != exp_off) begin
         errors++;
         $display("FAIL done_latency: got %0d cycles, required %0d", done_cyc - rdy_cyc, exp_off);
      end
      @(negedge clk);
      checks++;
      if ({busy, done, in_ready, we} !== 4'b0000 || (done_cnt - d0) != 1) begin
         errors++;
         $display("FAIL end_state: busy=%b done=%b ready=%b we=%b pulses=%0d, required 0 0 0 0 1",
                  busy, done, in_ready, we, done_cnt - d0);
      end
      checks++;
      if (err !== exp_err || sb.size() != 0) begin
         errors++;
         $display("FAIL err_sb: err=%b pending=%0d, required err=%b pending=0",
                  err, sb.size(), exp_err);
      end
   endtask

   task automatic check_ram(input logic [7:0] base, input logic [7:0] pl[$], input string nm);
      logic [7:0] a;
      foreach (pl[i]) begin
         a = base + 8'(i);
         checks++;
         if (mem[a] !== pl[i]) begin
            errors++;
            $display("FAIL %s: RAM[%h]=%h, required %h", nm, a, mem[a], pl[i]);
         end
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({addr, data_out, we, data_drive, in_ready, busy, done, err} !== 22'h0) begin
         errors++;
         $display("FAIL reset_state: addr=%h data=%h we=%b drv=%b rdy=%b busy=%b done=%b err=%b, required all 0",
                  addr, data_out, we, data_drive, in_ready, busy, done, err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({we, in_ready, busy, done} !== 4'b0000) begin
         errors++;
         $display("FAIL idle_state: we=%b rdy=%b busy=%b done=%b, required 0 0 0 0",
                  we, in_ready, busy, done);
      end
   endtask

   task automatic test_basic();
      logic [7:0] pl[$];
      int w0;
      pl = '{8'hA1, 8'hB2, 8'hC3};
      w0 = we_cnt;
      load(8'h10, 8'h03, pl, 1'b0, -1, csum_of(pl));
      check_ram(8'h10, pl, "basic_ram");
      checks++;
      if (we_cnt - w0 != 3) begin
         errors++;
         $display("FAIL basic_we_count: got %0d, required 3", we_cnt - w0);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] pl[$];
      pl = '{8'h01, 8'h02, 8'h03, 8'h04};
      load(8'hFE, 8'h04, pl, 1'b0, -1, csum_of(pl));
      check_ram(8'hFE, pl, "wrap_ram");
   endtask

   task automatic test_full();
      logic [7:0] pl[$];
      int w0;
      for (int i = 0; i < 256; i++) pl.push_back(8'(i));
      w0 = we_cnt;
      load(8'h00, 8'h00, pl, 1'b0, -1, csum_of(pl));
      check_ram(8'h00, pl, "full_ram");
      checks++;
      if (we_cnt - w0 != 256) begin
         errors++;
         $display("FAIL full_we_count: got %0d, required 256", we_cnt - w0);
      end
   endtask

   task automatic test_random_valid();
      logic [7:0] pl[$];
      int w0;
      pl = '{8'h3C, 8'h5A, 8'hC3, 8'h00, 8'hFF, 8'h96, 8'h69, 8'h81};
      w0 = we_cnt;
      load(8'h80, 8'h08, pl, 1'b1, 3, csum_of(pl));
      check_ram(8'h80, pl, "random_ram");
      checks++;
      if (we_cnt - w0 != 8) begin
         errors++;
         $display("FAIL random_we_count: got %0d, required 8", we_cnt - w0);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] old, pl[$];
      old = mem[8'h41];
      pulse_start();
      send_byte(8'h40, 1'b0);
      send_byte(8'h04, 1'b0);
      sb.push_back({8'h40, 8'h11});
      send_byte(8'h11, 1'b0);
      sb.push_back({8'h41, 8'h22});
      send_byte(8'h22, 1'b0);
      checks++;
      if (we !== 1'b1) begin
         errors++;
         $display("FAIL mid_write: we=%b before reset, required 1", we);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({we, busy, data_drive} !== 3'b000) begin
         errors++;
         $display("FAIL async_reset: we=%b busy=%b drive=%b, required 0 0 0", we, busy, data_drive);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({addr, data_out, we, in_ready, busy, done} !== 20'h0 || sb.size() != 0) begin
         errors++;
         $display("FAIL post_reset: addr=%h data=%h we=%b rdy=%b busy=%b done=%b pending=%0d, required all 0",
                  addr, data_out, we, in_ready, busy, done, sb.size());
      end
      checks++;
      if (mem[8'h41] !== old || mem[8'h40] !== 8'h11) begin
         errors++;
         $display("FAIL reset_ram: RAM[40]=%h RAM[41]=%h, required 11 and unchanged %h",
                  mem[8'h40], mem[8'h41], old);
      end
      pl = '{8'h5A, 8'hA5};
      load(8'h50, 8'h02, pl, 1'b0, -1, csum_of(pl));
      check_ram(8'h50, pl, "fresh_ram");
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] pl[$];
      pl = '{8'h01, 8'h02};
      load(8'h20, 8'h02, pl, 1'b0, -1, 8'hFD);
      load(8'h20, 8'h02, pl, 1'b0, -1, 8'hFC);
      repeat (4) @(negedge clk);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: err=%b while idle, required 1", err);
      end
      // The next start clears err; this load carries a good checksum.
      load(8'h20, 8'h02, pl, 1'b0, -1, 8'hFD);
      check_ram(8'h20, pl, "csum_ram");
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_full();
      test_random_valid();
      test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
